// File: rtl/spi_pkg.sv
// Shared types and defaults for the configurable SPI master.
// Build option: SPI_LOOPBACK_EN adds an internal mosi->sampler loopback.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CS_W   = 4;
  localparam int DEF_DIV_W  = 16;
  localparam int DEF_LEN_W  = 6;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock generator: half-period timer, edge counter, leading/trailing
// strobes and sclk toggling for one frame.
module spi_clk_gen #(
  parameter int DIV_W = 16,
  parameter int LEN_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             shift_i,
  input  logic             cpol_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             tick_o,
  output logic             lead_o,
  output logic             trail_o,
  output logic             done_o,
  output logic             sclk_o
);

  logic [DIV_W-1:0] hcnt_q, hcnt_d;
  logic [LEN_W:0]   ecnt_q, ecnt_d;
  logic             sclk_q, sclk_d;
  logic             edge_ev;
  logic [LEN_W:0]   last_edge;

  assign tick_o    = en_i && (hcnt_q == div_i);
  assign edge_ev   = shift_i && tick_o;
  assign last_edge = {len_i, 1'b0} - 1'b1;
  assign lead_o    = edge_ev && !ecnt_q[0];
  assign trail_o   = edge_ev &&  ecnt_q[0];
  assign done_o    = edge_ev && (ecnt_q == last_edge);
  assign sclk_o    = sclk_q;

  // While disabled the counters sit at zero so the first half-period after
  // accept is exactly div+1 cycles, and sclk tracks the idle level.
  always_comb begin
    hcnt_d = hcnt_q;
    ecnt_d = ecnt_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      hcnt_d = '0;
      ecnt_d = '0;
      sclk_d = cpol_i;
    end else begin
      hcnt_d = tick_o ? '0 : hcnt_q + 1'b1;
      if (edge_ev) begin
        ecnt_d = ecnt_q + 1'b1;
        sclk_d = ~sclk_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hcnt_q <= '0;
      ecnt_q <= '0;
      sclk_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      ecnt_q <= ecnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master_cfg.sv
// Runtime-configurable SPI master: per-frame length, mode, bit order, divider
// and chip select. Optional SPI_LOOPBACK_EN adds loopback_i.
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CS_W   = DEF_CS_W,
  parameter int DIV_W  = DEF_DIV_W,
  parameter int LEN_W  = DEF_LEN_W,
  localparam int SEL_W = sel_width(CS_W)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic [CS_W-1:0]   cs_bo,
  input  logic [SEL_W-1:0]  cs_sel_bi,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsb_first_i,
  input  logic [DIV_W-1:0]  clk_div_bi,
  input  logic [LEN_W-1:0]  len_bi,
  input  logic [DATA_W-1:0] data_tx_bi,
  input  logic              data_tx_wr_i,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback_i,
`endif
  output logic              busy_o,
  output logic [DATA_W-1:0] data_rx_bo,
  output logic              data_rx_wr_o
);

  spi_state_e state_q, state_d;

  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] data_rx_q, data_rx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CS_W-1:0]   cs_q, cs_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic mosi_q, mosi_d, rx_wr_q, rx_wr_d, busy_q, busy_d;

`ifdef SPI_LOOPBACK_EN
  logic loop_q, loop_d;
`else
  logic loop_q;
  assign loop_q = 1'b0;
`endif

  logic              accept, tick, lead, trail, done;
  logic              sample_ev, shift_ev, miso_s, cpol_gen;
  logic [LEN_W-1:0]  len_eff;
  logic [LEN_W:0]    tx_pad, rx_pad;
  logic [DATA_W-1:0] tx_align, tx_next;

  function automatic logic out_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift1(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  assign accept   = (state_q == ST_IDLE) && data_tx_wr_i;
  assign len_eff  = (len_bi == '0 || len_bi > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : len_bi;
  // MSB-first frames are left-aligned so the outgoing bit is always the MSB.
  assign tx_pad   = (LEN_W+1)'(DATA_W) - {1'b0, len_eff};
  assign tx_align = lsb_first_i ? data_tx_bi : (data_tx_bi << tx_pad);
  assign rx_pad   = (LEN_W+1)'(DATA_W) - {1'b0, len_q};
  assign tx_next  = shift1(tx_sh_q, lsb_q);
  assign cpol_gen = (state_q == ST_IDLE) ? cpol_i : cpol_q;

  spi_clk_gen #(
    .DIV_W (DIV_W),
    .LEN_W (LEN_W)
  ) u_clk_gen (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (state_q != ST_IDLE),
    .shift_i (state_q == ST_SHIFT),
    .cpol_i  (cpol_gen),
    .div_i   (div_q),
    .len_i   (len_q),
    .tick_o  (tick),
    .lead_o  (lead),
    .trail_o (trail),
    .done_o  (done),
    .sclk_o  (sclk_o)
  );

  // CPHA=0 shifts on trailing edges except after the final bit.
  assign sample_ev = cpha_q ? trail : lead;
  assign shift_ev  = cpha_q ? lead  : (trail && !done);
  assign miso_s    = loop_q ? mosi_q : miso_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (data_tx_wr_i) state_d = ST_SETUP;
      ST_SETUP: if (tick)         state_d = ST_SHIFT;
      ST_SHIFT: if (done)         state_d = ST_HOLD;
      ST_HOLD:  if (tick)         state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    data_rx_d = data_rx_q;
    len_d     = len_q;
    div_d     = div_q;
    sel_d     = sel_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    mosi_d    = mosi_q;
    rx_wr_d   = 1'b0;
`ifdef SPI_LOOPBACK_EN
    loop_d    = loop_q;
`endif
    if (accept) begin
      tx_sh_d = tx_align;
      rx_sh_d = '0;
      len_d   = len_eff;
      div_d   = clk_div_bi;
      sel_d   = cs_sel_bi;
      cpol_d  = cpol_i;
      cpha_d  = cpha_i;
      lsb_d   = lsb_first_i;
      if (!cpha_i) mosi_d = out_bit(tx_align, lsb_first_i);
`ifdef SPI_LOOPBACK_EN
      loop_d  = loopback_i;
`endif
    end
    if (sample_ev)
      rx_sh_d = lsb_q ? {miso_s, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], miso_s};
    if (shift_ev) begin
      if (cpha_q) begin
        mosi_d  = out_bit(tx_sh_q, lsb_q);
        tx_sh_d = tx_next;
      end else begin
        mosi_d  = out_bit(tx_next, lsb_q);
        tx_sh_d = tx_next;
      end
    end
    // LSB-first bits enter at the top; realign to bit 0 on completion.
    if (state_q == ST_HOLD && tick) begin
      data_rx_d = lsb_q ? (rx_sh_q >> rx_pad) : rx_sh_q;
      rx_wr_d   = 1'b1;
    end
  end

  always_comb begin
    busy_d = (state_d != ST_IDLE);
    cs_d   = '1;
`ifdef SPI_LOOPBACK_EN
    if (busy_d && !loop_d && int'(sel_d) < CS_W) cs_d[sel_d] = 1'b0;
`else
    if (busy_d && int'(sel_d) < CS_W) cs_d[sel_d] = 1'b0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      data_rx_q <= '0;
      len_q     <= '0;
      div_q     <= '0;
      sel_q     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      mosi_q    <= 1'b0;
      rx_wr_q   <= 1'b0;
      busy_q    <= 1'b0;
      cs_q      <= '1;
    end else begin
      state_q   <= state_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      data_rx_q <= data_rx_d;
      len_q     <= len_d;
      div_q     <= div_d;
      sel_q     <= sel_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      mosi_q    <= mosi_d;
      rx_wr_q   <= rx_wr_d;
      busy_q    <= busy_d;
      cs_q      <= cs_d;
    end
  end

`ifdef SPI_LOOPBACK_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) loop_q <= 1'b0;
    else          loop_q <= loop_d;
  end
`endif

  assign mosi_o       = mosi_q;
  assign cs_bo        = cs_q;
  assign busy_o       = busy_q;
  assign data_rx_bo   = data_rx_q;
  assign data_rx_wr_o = rx_wr_q;

endmodule
